instr_mem_loader: RTL and testbench
===================================

Name: instr_mem_loader

Overview:
- Write-side counterpart to the fetch path's instruction-memory reads.
- Accepts a byte stream over a valid/ready handshake and writes it into the byte-wide instruction memory starting at BASE_ADDR.
- Verifies an 8-bit additive checksum at the end of the stream.
- Holds the core (fetch onward) in reset while loading, and releases it only after a successful load.
- Sits between the boot/debug port and the instruction memory's write port.

Parameters:
- MEM_DEPTH, 1024: instruction memory size in bytes.
- ADDR_WIDTH, 32: width of mem_addr, matching the PC width.
- BASE_ADDR, 0: first byte address written.
- LEN_WIDTH, 16: width of load_len.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- load_start  input  1  single-cycle pulse that begins a load; ignored unless state is IDLE, DONE or ERROR.
- load_len  input  LEN_WIDTH  payload byte count, sampled when load_start is accepted.
- byte_data  input  8  stream byte.
- byte_valid  input  1  byte_data is valid.
- byte_ready  output  1  loader can accept a byte.
- mem_wr_en  output  1  instruction memory write strobe.
- mem_addr  output  ADDR_WIDTH  byte address of the write.
- mem_wr_data  output  8  byte to write.
- rd_wr  output  1  memory mode: 1 = read (fetch), 0 = write (load).
- core_rst  output  1  active-low reset to the core; 0 holds fetch in reset.
- load_busy  output  1  a load is in progress.
- load_done  output  1  last load passed the checksum (sticky).
- load_err  output  2  error code: 0 none, 1 length overflow, 2 checksum mismatch (sticky).

Behaviour:
- Reset values (asynchronous): state IDLE, byte_ready 0, mem_wr_en 0, mem_addr BASE_ADDR, mem_wr_data 0, rd_wr 1, core_rst 0, load_busy 0, load_done 0, load_err 0.
  - The core stays in reset after power-up until the first successful load.
- States: IDLE, LOAD, CHECK, DONE, ERROR.
- IDLE/DONE/ERROR + load_start:
  - Latch remaining = load_len; clear load_done and load_err; clear the running sum; set core_rst=0, rd_wr=0, load_busy=1.
  - If load_len > MEM_DEPTH - BASE_ADDR, go to ERROR with load_err=1 and write nothing.
  - Else if load_len == 0, go to CHECK.
  - Else go to LOAD.
- LOAD:
  - byte_ready=1. A beat is accepted when byte_valid && byte_ready.
  - Each accepted beat registers mem_wr_en=1, mem_wr_data=byte, mem_addr=write pointer on the next cycle (1-cycle write latency).
  - Each accepted beat increments the pointer, adds the byte to the sum modulo 256, and decrements remaining.
  - Back-to-back beats are allowed (one per cycle). byte_valid low inserts idle cycles with mem_wr_en=0.
  - When the final payload beat is accepted, go to CHECK.
- CHECK:
  - byte_ready=1. No memory write for this beat.
  - The next accepted byte is compared with the running sum.
  - Equal: go to DONE, set load_done=1, rd_wr=1, load_busy=0, and set core_rst=1 one cycle later so the last write lands first.
  - Not equal: go to ERROR, set load_err=2, load_busy=0, rd_wr=1, core_rst stays 0.
- DONE/ERROR: byte_ready=0. A new load_start restarts the load. DONE is the only state with core_rst=1.
- load_start during LOAD or CHECK is ignored.
- Write pointer: ADDR_WIDTH-bit; wrap-around cannot occur because length is checked at start.
- Address order is ascending, one byte per address; bytes are written exactly in stream order.
- Reset asserted mid-load: everything returns to reset values at once. Partially written memory is not erased, and core_rst stays 0.
- The memory itself is outside this block. rd_wr=0 whenever the loader may drive writes.

Decomposition:
- Shared package holds:
  - state encoding (IDLE=0, LOAD=1, CHECK=2, DONE=3, ERROR=4, 3-bit);
  - load_err codes (ERR_NONE, ERR_LEN, ERR_CSUM);
  - RD=1 / WR=0 constants for rd_wr.
- One sub-module is natural: loader_checksum, an 8-bit accumulator with clear/enable/compare.
- The FSM, pointer and handshake stay in instr_mem_loader.

Test Plan:
- Good load: load_len=8, bytes DE AD BE EF BA AD C0 DE, checksum 3D, valid every cycle.
  - Expect writes addr 0..7 with those bytes, each one cycle after acceptance.
  - Expect load_done=1 and load_err=0; core_rst rises one cycle after DONE; rd_wr returns to 1.
- Gapped stream: same bytes with byte_valid toggling 1/0.
  - Expect identical writes, mem_wr_en=0 on gap cycles, and the same final state.
- Bad checksum: same payload, checksum 3C.
  - Expect 8 writes, then ERROR, load_err=2, load_done=0, core_rst held 0.
- Length overflow: MEM_DEPTH=1024, load_len=1025.
  - Expect immediate ERROR, load_err=1, no mem_wr_en pulse, byte_ready never 1.
- Zero length: load_len=0, then byte 00.
  - Expect DONE with no writes; a byte 01 instead gives ERROR with load_err=2.
- Reset mid-load: assert rst low after 3 accepted bytes.
  - Expect all outputs at reset values immediately.
  - A fresh 8-byte load then completes correctly, and a load_start pulse sent during LOAD is ignored.

Source files
------------

// File: rtl/instr_mem_loader_pkg.sv
// Shared encodings for the instruction-memory loader: FSM states, error codes
// and the memory read/write mode values.
package instr_mem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CHECK = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } state_e;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_LEN  = 2'd1;
  localparam logic [1:0] ERR_CSUM = 2'd2;

  localparam logic RD = 1'b1;
  localparam logic WR = 1'b0;

endpackage

// File: rtl/instr_mem_loader_checksum.sv
// 8-bit additive (mod 256) accumulator with synchronous clear/enable and a
// combinational compare against a candidate checksum byte.
module loader_checksum (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic [7:0] data_i,
  input  logic [7:0] cmp_i,
  output logic [7:0] sum_o,
  output logic       match_o
);

  logic [7:0] sum_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sum_q <= 8'h00;
    end else if (clr_i) begin
      sum_q <= 8'h00;
    end else if (en_i) begin
      sum_q <= sum_q + data_i;
    end
  end

  assign sum_o   = sum_q;
  assign match_o = (cmp_i == sum_q);

endmodule

// File: rtl/instr_mem_loader.sv
// Streams a byte payload into instruction memory from BASE_ADDR upward, checks
// a trailing additive checksum, and keeps the core in reset until a good load.
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int MEM_DEPTH  = 1024,
  parameter int ADDR_WIDTH = 32,
  parameter int BASE_ADDR  = 0,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_start,
  input  logic [LEN_WIDTH-1:0]  load_len,
  input  logic [7:0]            byte_data,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wr_data,
  output logic                  rd_wr,
  output logic                  core_rst,
  output logic                  load_busy,
  output logic                  load_done,
  output logic [1:0]            load_err,
  output logic [2:0]            dbg_state
);

  localparam logic [31:0] LOAD_CAP = 32'(MEM_DEPTH - BASE_ADDR);

  // Handshake: a byte moves on any rising edge where byte_valid && byte_ready;
  // byte_ready depends only on state, never on byte_valid.
  state_e                state_q, state_d;
  logic [LEN_WIDTH-1:0]  remaining_q;
  logic [ADDR_WIDTH-1:0] ptr_q;
  logic                  wr_en_q, rd_wr_q, core_rst_q, busy_q, done_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            wdata_q;
  logic [1:0]            err_q;

  logic       start_acc, beat, len_bad, last_beat, load_beat, csum_match;
  logic [7:0] csum_sum;

  assign start_acc = load_start &&
                     (state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_ERROR);
  assign beat      = byte_valid && byte_ready;
  assign len_bad   = 32'(load_len) > LOAD_CAP;
  assign last_beat = (remaining_q == LEN_WIDTH'(1));
  assign load_beat = (state_q == ST_LOAD) && beat;

  loader_checksum u_csum (
    .clk_i   (clk),
    .rst_ni  (rst),
    .clr_i   (start_acc),
    .en_i    (load_beat),
    .data_i  (byte_data),
    .cmp_i   (byte_data),
    .sum_o   (csum_sum),
    .match_o (csum_match)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (load_start) begin
          if (len_bad)                     state_d = ST_ERROR;
          else if (load_len == '0)         state_d = ST_CHECK;
          else                             state_d = ST_LOAD;
        end
      end
      ST_LOAD:  if (beat && last_beat) state_d = ST_CHECK;
      ST_CHECK: if (beat) state_d = csum_match ? ST_DONE : ST_ERROR;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    byte_ready = (state_q == ST_LOAD) || (state_q == ST_CHECK);
    dbg_state  = state_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      remaining_q <= '0;
      ptr_q       <= ADDR_WIDTH'(BASE_ADDR);
      wr_en_q     <= 1'b0;
      addr_q      <= ADDR_WIDTH'(BASE_ADDR);
      wdata_q     <= 8'h00;
      rd_wr_q     <= RD;
      core_rst_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= ERR_NONE;
    end else begin
      wr_en_q    <= 1'b0;
      // Release the core one cycle after entering DONE so the final write lands first.
      core_rst_q <= (state_q == ST_DONE) && !start_acc;
      if (start_acc) begin
        remaining_q <= load_len;
        ptr_q       <= ADDR_WIDTH'(BASE_ADDR);
        done_q      <= 1'b0;
        err_q       <= len_bad ? ERR_LEN : ERR_NONE;
        busy_q      <= !len_bad;
        rd_wr_q     <= len_bad ? RD : WR;
      end
      if (load_beat) begin
        wr_en_q     <= 1'b1;
        addr_q      <= ptr_q;
        wdata_q     <= byte_data;
        ptr_q       <= ptr_q + 1'b1;
        remaining_q <= remaining_q - 1'b1;
      end
      if (state_q == ST_CHECK && beat) begin
        busy_q  <= 1'b0;
        rd_wr_q <= RD;
        if (csum_match) done_q <= 1'b1;
        else            err_q  <= ERR_CSUM;
      end
    end
  end

  assign mem_wr_en   = wr_en_q;
  assign mem_addr    = addr_q;
  assign mem_wr_data = wdata_q;
  assign rd_wr       = rd_wr_q;
  assign core_rst    = core_rst_q;
  assign load_busy   = busy_q;
  assign load_done   = done_q;
  assign load_err    = err_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: a cycle-by-cycle vector table for the
// good load, then hand sequences for gaps, errors, zero length and reset.
module tb_instr_mem_loader;
  import instr_mem_loader_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load_start = 1'b0;
  logic [15:0] load_len = '0;
  logic [7:0]  byte_data = '0;
  logic        byte_valid = 1'b0;
  logic        byte_ready, mem_wr_en, rd_wr, core_rst, load_busy, load_done;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wr_data;
  logic [1:0]  load_err;
  logic [2:0]  dbg_state;

  instr_mem_loader dut (
    .clk(clk), .rst(rst), .load_start(load_start), .load_len(load_len),
    .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .rd_wr(rd_wr), .core_rst(core_rst), .load_busy(load_busy),
    .load_done(load_done), .load_err(load_err), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  st;
    logic        ready, wr;
    logic [31:0] addr;
    logic [7:0]  wd;
    logic        rdwr, core, busy, done;
    logic [1:0]  err;
  } obs_t;

  typedef struct packed {
    logic        start;
    logic [15:0] len;
    logic        valid;
    logic [7:0]  data;
    obs_t        exp;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic        mon_en = 1'b0;
  logic [39:0] exp_q[$];
  logic [7:0]  pl[8];
  vec_t        tbl[12];
  obs_t        reset_obs;

  function automatic obs_t get_obs();
    return {dbg_state, byte_ready, mem_wr_en, mem_addr, mem_wr_data,
            rd_wr, core_rst, load_busy, load_done, load_err};
  endfunction

  function automatic obs_t mk_obs(logic [2:0] st, logic ready, logic wr, logic [31:0] addr,
                                  logic [7:0] wd, logic rdwr, logic core, logic busy,
                                  logic done, logic [1:0] err);
    return {st, ready, wr, addr, wd, rdwr, core, busy, done, err};
  endfunction

  function automatic vec_t mk_vec(logic start, logic [15:0] len, logic valid,
                                  logic [7:0] data, obs_t exp);
    return {start, len, valid, data, exp};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // Advance one cycle and score any memory write against the expected queue.
  task automatic tick();
    logic [39:0] e;
    @(posedge clk);
    #1;
    if (mon_en && mem_wr_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write got addr=%h data=%h want=no_write", mem_addr, mem_wr_data);
      end else begin
        e = exp_q.pop_front();
        chk("write", 64'({rd_wr, mem_addr, mem_wr_data}), 64'({1'b0, e}));
      end
    end
  endtask

  task automatic start_load(input logic [15:0] len);
    load_start = 1'b1;
    load_len   = len;
    tick();
    load_start = 1'b0;
  endtask

  task automatic beat(input logic [7:0] d);
    chk("ready_before_beat", 64'(byte_ready), 64'(1));
    byte_valid = 1'b1;
    byte_data  = d;
    tick();
    byte_valid = 1'b0;
  endtask

  initial begin
    pl = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hBA, 8'hAD, 8'hC0, 8'hDE};
    reset_obs = mk_obs(3'd0, 0, 0, 32'd0, 8'h00, 1, 0, 0, 0, 2'd0);
    tbl[0]  = mk_vec(1, 16'd8, 0, 8'h00, mk_obs(3'd1, 1, 0, 32'd0, 8'h00, 0, 0, 1, 0, 2'd0));
    tbl[1]  = mk_vec(0, 16'd0, 1, 8'hDE, mk_obs(3'd1, 1, 1, 32'd0, 8'hDE, 0, 0, 1, 0, 2'd0));
    tbl[2]  = mk_vec(0, 16'd0, 1, 8'hAD, mk_obs(3'd1, 1, 1, 32'd1, 8'hAD, 0, 0, 1, 0, 2'd0));
    tbl[3]  = mk_vec(0, 16'd0, 1, 8'hBE, mk_obs(3'd1, 1, 1, 32'd2, 8'hBE, 0, 0, 1, 0, 2'd0));
    tbl[4]  = mk_vec(0, 16'd0, 1, 8'hEF, mk_obs(3'd1, 1, 1, 32'd3, 8'hEF, 0, 0, 1, 0, 2'd0));
    tbl[5]  = mk_vec(0, 16'd0, 1, 8'hBA, mk_obs(3'd1, 1, 1, 32'd4, 8'hBA, 0, 0, 1, 0, 2'd0));
    tbl[6]  = mk_vec(0, 16'd0, 1, 8'hAD, mk_obs(3'd1, 1, 1, 32'd5, 8'hAD, 0, 0, 1, 0, 2'd0));
    tbl[7]  = mk_vec(0, 16'd0, 1, 8'hC0, mk_obs(3'd1, 1, 1, 32'd6, 8'hC0, 0, 0, 1, 0, 2'd0));
    tbl[8]  = mk_vec(0, 16'd0, 1, 8'hDE, mk_obs(3'd2, 1, 1, 32'd7, 8'hDE, 0, 0, 1, 0, 2'd0));
    tbl[9]  = mk_vec(0, 16'd0, 1, 8'h3D, mk_obs(3'd3, 0, 0, 32'd7, 8'hDE, 1, 0, 0, 1, 2'd0));
    tbl[10] = mk_vec(0, 16'd0, 0, 8'h00, mk_obs(3'd3, 0, 0, 32'd7, 8'hDE, 1, 1, 0, 1, 2'd0));
    tbl[11] = mk_vec(0, 16'd0, 0, 8'h00, mk_obs(3'd3, 0, 0, 32'd7, 8'hDE, 1, 1, 0, 1, 2'd0));

    // Clock/reset
    #12;
    chk("reset_state", 64'(get_obs()), 64'(reset_obs));
    #8 rst = 1'b1;

    // Good load, cycle by cycle
    for (int i = 0; i < 12; i++) begin
      load_start = tbl[i].start;
      load_len   = tbl[i].len;
      byte_valid = tbl[i].valid;
      byte_data  = tbl[i].data;
      @(posedge clk);
      #1;
      chk($sformatf("good_vec%0d", i), 64'(get_obs()), 64'(tbl[i].exp));
    end
    load_start = 1'b0;
    byte_valid = 1'b0;
    mon_en     = 1'b1;

    // Gapped stream
    start_load(16'd8);
    chk("gap_start_state", 64'(dbg_state), 64'(ST_LOAD));
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back({32'(i), pl[i]});
      beat(pl[i]);
      tick();
      chk("gap_idle_no_write", 64'(mem_wr_en), 64'(0));
    end
    beat(8'h3D);
    chk("gap_final", 64'({dbg_state, load_done, load_err, core_rst, rd_wr, load_busy}),
        64'({ST_DONE, 1'b1, ERR_NONE, 1'b0, 1'b1, 1'b0}));
    tick();
    chk("gap_core_release", 64'(core_rst), 64'(1));
    chk("gap_all_written", 64'(exp_q.size()), 64'(0));

    // Bad checksum
    start_load(16'd8);
    chk("bad_core_held_on_start", 64'(core_rst), 64'(0));
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back({32'(i), pl[i]});
      beat(pl[i]);
    end
    beat(8'h3C);
    chk("bad_final", 64'({dbg_state, load_done, load_err, core_rst, rd_wr, load_busy}),
        64'({ST_ERROR, 1'b0, ERR_CSUM, 1'b0, 1'b1, 1'b0}));
    tick();
    tick();
    chk("bad_core_still_held", 64'(core_rst), 64'(0));
    chk("bad_all_written", 64'(exp_q.size()), 64'(0));

    // Length overflow: one past capacity
    start_load(16'd1025);
    chk("ovf_state", 64'({dbg_state, load_err, byte_ready, load_done}),
        64'({ST_ERROR, ERR_LEN, 1'b0, 1'b0}));
    byte_valid = 1'b1;
    byte_data  = 8'h55;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("ovf_never_ready", 64'(byte_ready), 64'(0));
    end
    byte_valid = 1'b0;

    // Zero length: checksum of empty payload is 00
    start_load(16'd0);
    chk("zero_check_state", 64'({dbg_state, byte_ready}), 64'({ST_CHECK, 1'b1}));
    beat(8'h00);
    chk("zero_good", 64'({dbg_state, load_done, load_err}), 64'({ST_DONE, 1'b1, ERR_NONE}));
    start_load(16'd0);
    beat(8'h01);
    chk("zero_bad", 64'({dbg_state, load_done, load_err}), 64'({ST_ERROR, 1'b0, ERR_CSUM}));

    // Exact-capacity length accepted, then reset mid-load
    start_load(16'd1024);
    chk("cap_len_accepted", 64'(dbg_state), 64'(ST_LOAD));
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({32'(i), pl[i]});
      beat(pl[i]);
    end
    #2 rst = 1'b0;
    #1;
    chk("midload_reset_state", 64'(get_obs()), 64'(reset_obs));
    chk("midload_writes_seen", 64'(exp_q.size()), 64'(0));
    #1 rst = 1'b1;

    // Fresh load with an ignored start mid-stream
    start_load(16'd8);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back({32'(i), pl[i]});
      if (i == 3) begin
        load_start = 1'b1;
        load_len   = 16'd1025;
      end
      beat(pl[i]);
      load_start = 1'b0;
      if (i == 3) chk("start_ignored_in_load", 64'({dbg_state, load_err}), 64'({ST_LOAD, ERR_NONE}));
    end
    beat(8'h3D);
    chk("fresh_final", 64'({dbg_state, load_done, load_err, rd_wr}),
        64'({ST_DONE, 1'b1, ERR_NONE, 1'b1}));
    tick();
    chk("fresh_core_release", 64'(core_rst), 64'(1));
    chk("fresh_all_written", 64'(exp_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
